// File: rtl/popcount_pipe.sv
// popcount_pipe: streaming pipelined popcount of a W-bit word; optional per-packet accumulation under POPCOUNT_PIPE_ACC_EN.
// Latency 1 + ceil(ceil(log2 W)/STEP) cycles, one word per cycle while out_ready is high.
// Backpressure: the whole pipe holds when out_valid & !out_ready; in_ready follows out_ready combinationally.
module popcount_pipe #(
  parameter int W     = 32,
  parameter int STEP  = 2,
  parameter int ACC_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_count,
  output logic             out_sat
);
  localparam int D  = (W > 1) ? $clog2(W) : 0;
  localparam int S  = (D + STEP - 1) / STEP;
  localparam int CW = $clog2(W + 1);

  logic             adv;
  logic             fin_vld;
  logic             fin_last;
  logic [ACC_W-1:0] fin_cnt;
  logic             vld_q;
  logic [ACC_W-1:0] cnt_q;

  assign adv      = !vld_q | out_ready;
  assign in_ready = adv & !reset;

  // Level k of the tree holds ceil(W/2^k) operands of k+1 bits (capped at CW,
  // which is still exact because the true total never exceeds W).
  for (genvar k = 0; k <= D; k++) begin : g_lvl
    localparam int N  = (W + (1 << k) - 1) >> k;
    localparam int LW = (k + 1 < CW) ? k + 1 : CW;
    logic [LW-1:0] sum [N];
    logic [LW-1:0] v   [N];

    if (k == 0) begin : g_in
      for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i] = in_data[i];
      end
    end else begin : g_add
      localparam int PN = (W + (1 << (k - 1)) - 1) >> (k - 1);
      for (genvar i = 0; i < N; i++) begin : g_op
        if (2 * i + 1 < PN) begin : g_pair
          assign sum[i] = LW'(g_lvl[k-1].v[2*i]) + LW'(g_lvl[k-1].v[2*i+1]);
        end else begin : g_odd
          assign sum[i] = LW'(g_lvl[k-1].v[2*i]);
        end
      end
    end

    // Intermediate data needs no reset: only valid beats ever reach the output register.
    if (k < D && k % STEP == 0) begin : g_reg
      logic [LW-1:0] q [N];
      always_ff @(posedge clock) begin
        if (adv) q <= sum;
      end
      assign v = q;
    end else begin : g_comb
      assign v = sum;
    end
  end

  assign fin_cnt = ACC_W'(g_lvl[D].v[0]);

  if (S == 0) begin : g_vld0
    assign fin_vld  = in_valid & in_ready;
    assign fin_last = in_last;
  end else begin : g_vldp
    logic [S-1:0] pv_q;
    logic [S-1:0] pl_q;
    always_ff @(posedge clock) begin
      if (reset) begin
        pv_q <= '0;
        pl_q <= '0;
      end else if (adv) begin
        pv_q[0] <= in_valid;
        pl_q[0] <= in_last;
        for (int s = 1; s < S; s++) begin
          pv_q[s] <= pv_q[s-1];
          pl_q[s] <= pl_q[s-1];
        end
      end
    end
    assign fin_vld  = pv_q[S-1];
    assign fin_last = pl_q[S-1];
  end

`ifdef POPCOUNT_PIPE_ACC_EN
  logic [ACC_W-1:0] acc_q;
  logic             sticky_q;
  logic             sat_q;
  logic [ACC_W:0]   total;
  logic             ovf;
  logic [ACC_W-1:0] acc_next;

  always_comb begin
    total    = {1'b0, acc_q} + {1'b0, fin_cnt};
    ovf      = total[ACC_W];
    acc_next = ovf ? '1 : total[ACC_W-1:0];
  end

  // A last beat publishes the running total and restarts the packet in the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q    <= 1'b0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
    end else if (adv) begin
      vld_q <= fin_vld & fin_last;
      if (fin_vld) begin
        if (fin_last) begin
          cnt_q    <= acc_next;
          sat_q    <= sticky_q | ovf;
          acc_q    <= '0;
          sticky_q <= 1'b0;
        end else begin
          acc_q    <= acc_next;
          sticky_q <= sticky_q | ovf;
        end
      end
    end
  end

  assign out_sat = sat_q;
`else
  logic unused_last;
  assign unused_last = fin_last;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else if (adv) begin
      vld_q <= fin_vld;
      if (fin_vld) cnt_q <= fin_cnt;
    end
  end

  assign out_sat = 1'b0;
`endif

  assign out_valid = vld_q;
  assign out_count = cnt_q;
endmodule

// File: tb/tb_popcount_pipe.sv
// Directed bench for popcount_pipe: per-word mode on W=32/STEP=2 and W=5/STEP=1, plus accumulate mode when enabled.
module tb_popcount_pipe;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  logic        a_iv = 1'b0, a_ir, a_il = 1'b0, a_ov, a_or = 1'b1, a_sat;
  logic [31:0] a_id = '0;
  logic [15:0] a_cnt;
  popcount_pipe #(.W(32), .STEP(2), .ACC_W(16)) dut_a (
    .clock(clock), .reset(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .in_last(a_il), .out_valid(a_ov), .out_ready(a_or), .out_count(a_cnt), .out_sat(a_sat));

  logic        b_iv = 1'b0, b_ir, b_il = 1'b0, b_ov, b_or = 1'b1, b_sat;
  logic [4:0]  b_id = '0;
  logic [15:0] b_cnt;
  popcount_pipe #(.W(5), .STEP(1), .ACC_W(16)) dut_b (
    .clock(clock), .reset(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .in_last(b_il), .out_valid(b_ov), .out_ready(b_or), .out_count(b_cnt), .out_sat(b_sat));

`ifdef POPCOUNT_PIPE_ACC_EN
  logic        c_iv = 1'b0, c_ir, c_il = 1'b0, c_ov, c_or = 1'b1, c_sat;
  logic [7:0]  c_id = '0;
  logic [15:0] c_cnt;
  popcount_pipe #(.W(8), .STEP(2), .ACC_W(16)) dut_c (
    .clock(clock), .reset(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
    .in_last(c_il), .out_valid(c_ov), .out_ready(c_or), .out_count(c_cnt), .out_sat(c_sat));

  logic        d_iv = 1'b0, d_ir, d_il = 1'b0, d_ov, d_or = 1'b1, d_sat;
  logic [7:0]  d_id = '0;
  logic [3:0]  d_cnt;
  popcount_pipe #(.W(8), .STEP(2), .ACC_W(4)) dut_d (
    .clock(clock), .reset(rst), .in_valid(d_iv), .in_ready(d_ir), .in_data(d_id),
    .in_last(d_il), .out_valid(d_ov), .out_ready(d_or), .out_count(d_cnt), .out_sat(d_sat));
`endif

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (a_ov !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", a_ov); else passed++;
    checks++; if (a_cnt !== 16'd0) $display("FAIL reset_out_count got %0d exp 0", a_cnt); else passed++;
    checks++; if (a_sat !== 1'b0) $display("FAIL reset_out_sat got %b exp 0", a_sat); else passed++;
    checks++; if (a_ir !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", a_ir); else passed++;
    checks++; if (b_ov !== 1'b0) $display("FAIL reset_w5_out_valid got %b exp 0", b_ov); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (a_ir !== 1'b1) $display("FAIL reset_release_in_ready got %b exp 1", a_ir); else passed++;
    @(posedge clock);
    #1;
    checks++; if (a_ov !== 1'b0 || a_cnt !== 16'd0)
      $display("FAIL reset_idle got valid %b count %0d exp 0/0", a_ov, a_cnt); else passed++;
  endtask

  task automatic test_basic();
    logic [31:0] w [4];
    int          exp_c [4];
    logic        exp_v;
    w     = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0001, 32'h5555_5555};
    exp_c = '{0, 32, 2, 16};
    a_or = 1'b1;
    a_il = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (c < 4) begin
        a_iv = 1'b1;
        a_id = w[c];
      end else begin
        a_iv = 1'b0;
        a_id = '0;
      end
      #1;
      if (c < 4) begin
        checks++; if (a_ir !== 1'b1) $display("FAIL basic_in_ready c=%0d got %b exp 1", c, a_ir); else passed++;
      end
      @(posedge clock);
      #1;
      exp_v = (c >= 3 && c <= 6);
      checks++; if (a_ov !== exp_v) $display("FAIL basic_valid c=%0d got %b exp %b", c, a_ov, exp_v); else passed++;
      if (exp_v) begin
        checks++; if (a_cnt !== 16'(exp_c[c-3]) || a_sat !== 1'b0)
          $display("FAIL basic_count c=%0d got %0d sat %b exp %0d sat 0", c, a_cnt, a_sat, exp_c[c-3]); else passed++;
      end
    end
  endtask

  task automatic test_w5();
    logic exp_v;
    int   exp_c;
    b_or = 1'b1;
    for (int c = 0; c < 8; c++) begin
      b_iv = (c < 2);
      if (c == 0) b_id = 5'b11111;
      else if (c == 1) b_id = 5'b10100;
      else b_id = '0;
      @(posedge clock);
      #1;
      exp_v = (c == 3 || c == 4);
      exp_c = (c == 3) ? 5 : 2;
      checks++; if (b_ov !== exp_v) $display("FAIL w5_valid c=%0d got %b exp %b", c, b_ov, exp_v); else passed++;
      if (exp_v) begin
        checks++; if (b_cnt !== 16'(exp_c)) $display("FAIL w5_count c=%0d got %0d exp %0d", c, b_cnt, exp_c); else passed++;
      end
    end
    b_iv = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] w [8];
    int          exp_c [8];
    logic        pat [4];
    int          sent = 0;
    int          got = 0;
    logic        hold = 1'b0;
    logic [15:0] held = '0;
    w     = '{32'h0000_0001, 32'h0000_0003, 32'h0000_000F, 32'h0000_00FF,
              32'h0000_FFFF, 32'hFFFF_FFFF, 32'hF0F0_F0F0, 32'h1234_5678};
    exp_c = '{1, 2, 4, 8, 16, 32, 16, 13};
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 40; c++) begin
      a_or = pat[c % 4];
      a_iv = (sent < 8);
      if (sent < 8) a_id = w[sent]; else a_id = '0;
      #1;
      if (hold) begin
        checks++; if (a_ov !== 1'b1 || a_cnt !== held)
          $display("FAIL bp_stall_hold c=%0d got valid %b count %0d exp 1/%0d", c, a_ov, a_cnt, held); else passed++;
      end
      hold = 1'b0;
      if (a_ov === 1'b1) begin
        checks++; if (a_ir !== a_or) $display("FAIL bp_in_ready c=%0d got %b exp %b", c, a_ir, a_or); else passed++;
        if (a_or) begin
          checks++;
          if (got < 8 && a_cnt === 16'(exp_c[got])) passed++;
          else $display("FAIL bp_result idx=%0d got %0d exp %0d", got, a_cnt, (got < 8) ? exp_c[got] : -1);
          got++;
        end else begin
          hold = 1'b1;
          held = a_cnt;
        end
      end
      if (a_iv && a_ir) sent++;
      @(posedge clock);
      #1;
    end
    a_or = 1'b1;
    a_iv = 1'b0;
    checks++; if (got != 8) $display("FAIL bp_result_count got %0d exp 8", got); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] w [3];
    int          bad = 0;
    logic        exp_v;
    w = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_00FF};
    a_or = 1'b1;
    for (int c = 0; c < 3; c++) begin
      a_iv = 1'b1;
      a_id = w[c];
      @(posedge clock);
      #1;
    end
    a_iv = 1'b0;
    a_id = '0;
    rst  = 1'b1;
    #1;
    checks++; if (a_ir !== 1'b0) $display("FAIL rmid_in_ready got %b exp 0", a_ir); else passed++;
    @(posedge clock);
    #1;
    rst = 1'b0;
    checks++; if (a_ov !== 1'b0 || a_cnt !== 16'd0)
      $display("FAIL rmid_after_reset got valid %b count %0d exp 0/0", a_ov, a_cnt); else passed++;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock);
      #1;
      if (a_ov !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL rmid_flushed got %0d stray results exp 0", bad); else passed++;
    for (int c = 0; c < 6; c++) begin
      a_iv = (c == 0);
      a_id = (c == 0) ? 32'h0000_00F0 : 32'h0;
      @(posedge clock);
      #1;
      exp_v = (c == 3);
      checks++; if (a_ov !== exp_v) $display("FAIL rmid_new_valid c=%0d got %b exp %b", c, a_ov, exp_v); else passed++;
      if (exp_v) begin
        checks++; if (a_cnt !== 16'd4) $display("FAIL rmid_new_count got %0d exp 4", a_cnt); else passed++;
      end
    end
    a_iv = 1'b0;
  endtask

`ifdef POPCOUNT_PIPE_ACC_EN
  task automatic test_accumulate();
    logic [7:0] d [4];
    logic       l [4];
    int         got_c [$];
    int         got_s [$];
    d = '{8'hFF, 8'h0F, 8'h01, 8'h03};
    l = '{1'b0, 1'b0, 1'b1, 1'b1};
    c_or = 1'b1;
    for (int c = 0; c < 12; c++) begin
      c_iv = (c < 4);
      c_id = (c < 4) ? d[c % 4] : 8'h00;
      c_il = (c < 4) ? l[c % 4] : 1'b0;
      @(posedge clock);
      #1;
      if (c_ov === 1'b1) begin
        got_c.push_back(int'(c_cnt));
        got_s.push_back(int'(c_sat));
      end
    end
    c_iv = 1'b0;
    checks++; if (got_c.size() != 2) $display("FAIL acc_result_count got %0d exp 2", got_c.size()); else passed++;
    checks++; if (((got_c.size() > 0) ? got_c[0] : -1) != 13 || ((got_s.size() > 0) ? got_s[0] : -1) != 0)
      $display("FAIL acc_packet got %0d sat %0d exp 13 sat 0", (got_c.size() > 0) ? got_c[0] : -1,
               (got_s.size() > 0) ? got_s[0] : -1); else passed++;
    checks++; if (((got_c.size() > 1) ? got_c[1] : -1) != 2 || ((got_s.size() > 1) ? got_s[1] : -1) != 0)
      $display("FAIL acc_single got %0d sat %0d exp 2 sat 0", (got_c.size() > 1) ? got_c[1] : -1,
               (got_s.size() > 1) ? got_s[1] : -1); else passed++;
  endtask

  task automatic test_acc_saturation();
    logic [7:0] d [3];
    logic       l [3];
    int         got_c [$];
    int         got_s [$];
    d = '{8'hFF, 8'hFF, 8'h01};
    l = '{1'b0, 1'b1, 1'b1};
    d_or = 1'b1;
    for (int c = 0; c < 10; c++) begin
      d_iv = (c < 3);
      d_id = (c < 3) ? d[c % 3] : 8'h00;
      d_il = (c < 3) ? l[c % 3] : 1'b0;
      @(posedge clock);
      #1;
      if (d_ov === 1'b1) begin
        got_c.push_back(int'(d_cnt));
        got_s.push_back(int'(d_sat));
      end
    end
    d_iv = 1'b0;
    checks++; if (got_c.size() != 2) $display("FAIL sat_result_count got %0d exp 2", got_c.size()); else passed++;
    checks++; if (((got_c.size() > 0) ? got_c[0] : -1) != 15 || ((got_s.size() > 0) ? got_s[0] : -1) != 1)
      $display("FAIL sat_packet got %0d sat %0d exp 15 sat 1", (got_c.size() > 0) ? got_c[0] : -1,
               (got_s.size() > 0) ? got_s[0] : -1); else passed++;
    checks++; if (((got_c.size() > 1) ? got_c[1] : -1) != 1 || ((got_s.size() > 1) ? got_s[1] : -1) != 0)
      $display("FAIL sat_next_packet got %0d sat %0d exp 1 sat 0", (got_c.size() > 1) ? got_c[1] : -1,
               (got_s.size() > 1) ? got_s[1] : -1); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_w5();
    test_backpressure();
    test_reset_mid();
`ifdef POPCOUNT_PIPE_ACC_EN
    test_accumulate();
    test_acc_saturation();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, %0d/%0d checks passed so far", passed, checks);
    $fatal(1);
  end
endmodule
